// File: rtl/bus_mem_slave.sv
// Single-port register-memory slave: one outstanding request, programmable wait
// states, then a held response (read data + range error) until the master takes it.
module bus_mem_slave #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  txn_count,
    output logic [1:0]        dbg_state
);

    // Handshake rule on both channels: a transfer happens on the rising edge where
    // valid && ready are both high; a source holds valid and its payload until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]      WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam int              NWORDS    = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rdy_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    txn_count_q;
    logic [DATA_W-1:0]   mem_q [NWORDS];

    logic                accept;
    logic                rsp_hs;
    logic                req_in_range;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic                sel_in_range;

    assign accept       = req_valid && req_ready;
    assign rsp_hs       = rsp_valid && rsp_ready;
    assign req_in_range = {1'b0, req_addr} < DEPTH_C;

    // State register plus datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            txn_count_q <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
            end
            if (accept && req_write && req_in_range) begin
                mem_q[req_addr] <= req_wdata;
            end
            if (rsp_hs) begin
                txn_count_q <= txn_count_q + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the response loads on the accept edge itself, so the
    // request bus is used directly instead of the not-yet-captured copy.
    always_comb begin
        sel_addr     = (state_q == S_IDLE) ? req_addr : addr_q;
        sel_write    = (state_q == S_IDLE) ? req_write : write_q;
        sel_in_range = {1'b0, sel_addr} < DEPTH_C;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        if (state_d == S_RESP && state_q != S_RESP) begin
            rsp_err_d   = !sel_in_range;
            rsp_rdata_d = (!sel_write && sel_in_range) ? mem_q[sel_addr] : '0;
        end else if (rsp_hs) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end
    end

    assign req_ready = rdy_en_q && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_count_q;
    assign dbg_state = state_q;

endmodule
